// File: rtl/flow_mem_pkg.sv
// Shared definitions for the datapath memory port arbiter: address-space and
// requester encodings plus the tag that follows a load through its read latency.
package flow_mem_pkg;

    localparam logic SPACE_MEMORY = 1'b0;
    localparam logic SPACE_STACK  = 1'b1;

    localparam logic REQ_A = 1'b0;
    localparam logic REQ_B = 1'b1;

    typedef struct packed {
        logic valid;
        logic owner;
        logic space;
    } rsp_tag_t;

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way arbiter: round-robin on contention unless prio_b_i forces B to win.
// Grant is one-hot (or zero) and suppressed while reset is high.
module rr_arbiter_2
    import flow_mem_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] req_i,
    input  logic       prio_b_i,
    output logic [1:0] grant_o
);

    logic last_grant_q;
    logic last_grant_d;

    always_ff @(posedge clock) begin
        if (reset) begin
            last_grant_q <= REQ_B;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

    // On contention the requester that did not win last time goes next.
    always_comb begin
        grant_o = 2'b00;
        if (!reset) begin
            if (req_i[REQ_A] && req_i[REQ_B]) begin
                if (prio_b_i || (last_grant_q == REQ_A)) begin
                    grant_o[REQ_B] = 1'b1;
                end else begin
                    grant_o[REQ_A] = 1'b1;
                end
            end else begin
                grant_o = req_i;
            end
        end
    end

    always_comb begin
        last_grant_d = last_grant_q;
        if (grant_o[REQ_B]) begin
            last_grant_d = REQ_B;
        end else if (grant_o[REQ_A]) begin
            last_grant_d = REQ_A;
        end
    end

endmodule

// File: rtl/memory_port_arbiter.sv
// Shares the memory data port between the load/store unit (A) and debug port (B).
// Handshake: request and its fields stay stable until grant is seen high; the access commits at that edge.
module memory_port_arbiter
    import flow_mem_pkg::*;
#(
    parameter int ADDR_WIDTH       = 16,
    parameter int DATA_WIDTH       = 16,
    parameter int FIXED_PRIORITY_B = 0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  a_request,
    input  logic                  a_write,
    input  logic                  a_space,
    input  logic [ADDR_WIDTH-1:0] a_address,
    input  logic [DATA_WIDTH-1:0] a_wdata,
    output logic                  a_grant,
    output logic                  a_rvalid,
    output logic [DATA_WIDTH-1:0] a_rdata,
    input  logic                  b_request,
    input  logic                  b_write,
    input  logic                  b_space,
    input  logic [ADDR_WIDTH-1:0] b_address,
    input  logic [DATA_WIDTH-1:0] b_wdata,
    output logic                  b_grant,
    output logic                  b_rvalid,
    output logic [DATA_WIDTH-1:0] b_rdata,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_value,
    output logic                  mem_memory_store_enable,
    output logic                  mem_stack_store_enable,
    input  logic [DATA_WIDTH-1:0] mem_at_memory,
    input  logic [DATA_WIDTH-1:0] mem_at_stack
);

    logic [1:0]            grant;
    logic                  granted;
    logic                  winner;
    logic                  sel_write;
    logic                  sel_space;
    logic [ADDR_WIDTH-1:0] sel_address;
    logic [DATA_WIDTH-1:0] sel_wdata;
    logic [ADDR_WIDTH-1:0] addr_hold_q;
    logic [ADDR_WIDTH-1:0] addr_hold_d;
    rsp_tag_t              rsp_q;
    rsp_tag_t              rsp_d;
    logic [DATA_WIDTH-1:0] rdata_sel;

    rr_arbiter_2 u_arb (
        .clock    (clock),
        .reset    (reset),
        .req_i    ({b_request, a_request}),
        .prio_b_i (FIXED_PRIORITY_B != 0),
        .grant_o  (grant)
    );

    assign granted     = |grant;
    assign winner      = grant[REQ_B] ? REQ_B : REQ_A;
    assign sel_write   = (winner == REQ_B) ? b_write   : a_write;
    assign sel_space   = (winner == REQ_B) ? b_space   : a_space;
    assign sel_address = (winner == REQ_B) ? b_address : a_address;
    assign sel_wdata   = (winner == REQ_B) ? b_wdata   : a_wdata;

    assign a_grant = grant[REQ_A];
    assign b_grant = grant[REQ_B];

    // Idle cycles keep presenting the last address so the memory read-back stays stable.
    always_comb begin
        mem_address             = addr_hold_q;
        mem_value               = '0;
        mem_memory_store_enable = 1'b0;
        mem_stack_store_enable  = 1'b0;
        if (granted) begin
            mem_address             = sel_address;
            mem_value               = sel_wdata;
            mem_memory_store_enable = sel_write && (sel_space == SPACE_MEMORY);
            mem_stack_store_enable  = sel_write && (sel_space == SPACE_STACK);
        end
    end

    always_comb begin
        addr_hold_d = granted ? sel_address : addr_hold_q;
        rsp_d.valid = granted && !sel_write;
        rsp_d.owner = winner;
        rsp_d.space = sel_space;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            addr_hold_q <= '0;
            rsp_q       <= '0;
        end else begin
            addr_hold_q <= addr_hold_d;
            rsp_q       <= rsp_d;
        end
    end

    assign rdata_sel = (rsp_q.space == SPACE_STACK) ? mem_at_stack : mem_at_memory;
    assign a_rvalid  = !reset && rsp_q.valid && (rsp_q.owner == REQ_A);
    assign b_rvalid  = !reset && rsp_q.valid && (rsp_q.owner == REQ_B);
    assign a_rdata   = a_rvalid ? rdata_sel : '0;
    assign b_rdata   = b_rvalid ? rdata_sel : '0;

endmodule

// File: doc/memory_port_arbiter.md
Name: memory_port_arbiter

Overview:
- Shares the single data port of the datapath memory block (address/value/store enables, at_memory/at_stack read-back) between two requesters: the core load/store unit (requester A) and the debug/loader port (requester B).
- Performs per-cycle arbitration and drives the memory port.
- Tracks the one-cycle read latency and routes read data back to the requester that issued the read.
- The instruction-fetch port (program_counter/current_instruction) is not arbitrated and bypasses this block.

Parameters:
- ADDR_WIDTH, 16, width of word address.
- DATA_WIDTH, 16, width of data word.
- FIXED_PRIORITY_B, 0: 0 = round-robin between A and B; 1 = B always wins.

Ports:
- clock  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high reset
- a_request  in  1  A requests an access this cycle
- a_write  in  1  1 = store, 0 = load
- a_space  in  1  0 = main memory, 1 = stack
- a_address  in  ADDR_WIDTH  access address
- a_wdata  in  DATA_WIDTH  store data
- a_grant  out  1  A's access is issued to memory this cycle
- a_rvalid  out  1  A's load data valid this cycle
- a_rdata  out  DATA_WIDTH  A's load data
- b_request, b_write, b_space, b_address, b_wdata, b_grant, b_rvalid, b_rdata: same as A, for requester B
- mem_address  out  ADDR_WIDTH  to memory address
- mem_value  out  DATA_WIDTH  to memory value
- mem_memory_store_enable  out  1  to memory_store_enable
- mem_stack_store_enable  out  1  to stack_store_enable
- mem_at_memory  in  DATA_WIDTH  from memory at_memory
- mem_at_stack  in  DATA_WIDTH  from memory at_stack

Behaviour:
- Reset (reset high at a rising edge):
  - last_grant is set to B, so A has preference next.
  - Response pipeline valid bit is cleared.
  - Held mem_address is set to 0.
  - While reset is high: all grants are 0, both store enables are 0, a_rvalid/b_rvalid are 0, rdata outputs are 0.
- Grant (combinational from requests and last_grant):
  - Only one requester: it is granted.
  - Both requesting with FIXED_PRIORITY_B=1: B is granted.
  - Both requesting with FIXED_PRIORITY_B=0: the requester other than last_grant is granted.
  - At most one grant is high per cycle.
- Handshake:
  - The requester holds request, write, space, address and wdata stable until it sees grant high.
  - The access is committed at the rising edge ending the grant cycle.
  - The requester may drop or change its request in the following cycle.
  - Back-to-back requests are allowed; a continuously requesting sole requester is granted every cycle.
- Memory drive (granted cycle):
  - mem_address and mem_value come from the winner.
  - mem_memory_store_enable = write & ~space.
  - mem_stack_store_enable = write & space.
- Memory drive (no grant):
  - Both enables are 0.
  - mem_address holds the last granted address, a registered copy, so the memory outputs stay stable.
  - mem_value is 0.
- last_grant updates at every edge where a grant occurred. It does not change in idle cycles.
- Read latency:
  - The memory registers at_memory/at_stack on the access edge.
  - The arbiter registers {valid = granted & ~write, owner, space} on that edge.
  - In the next cycle, the owner's rvalid = 1 and its rdata = space ? mem_at_stack : mem_at_memory.
  - The load response therefore arrives exactly 1 cycle after the grant cycle.
  - The non-owner's rvalid is 0 and its rdata is 0.
- Stores produce no rvalid.
- Pipelining: a new grant may be issued in the same cycle a previous load's rvalid is presented. One response is in flight at most.
- Read-after-write to the same address on consecutive grants returns the new data. Write ordering is strictly grant order.
- Reset mid-operation: a load granted in the cycle before reset produces no rvalid. Arbitration restarts with A preferred.

Decomposition:
- Package flow_mem_pkg holds:
  - SPACE_MEMORY = 1'b0 and SPACE_STACK = 1'b1.
  - REQ_A = 1'b0 and REQ_B = 1'b1 requester IDs.
  - A response-tag struct {valid, owner, space}.
- Sub-module rr_arbiter_2 is natural: two request lines, a priority mode input and a last_grant register, producing a one-hot grant.

Test Plan:
- Reset, then A stores 16'h1234 to memory address 16'h0010; next cycle A loads 16'h0010 -> a_grant=1 on both cycles, a_rvalid=1 one cycle after the load grant with a_rdata=16'h1234, b_rvalid=0.
- A and B request continuously, FIXED_PRIORITY_B=0 -> first grant goes to A after reset, then grants alternate A,B,A,B with no idle cycles.
- Same stimulus with FIXED_PRIORITY_B=1 -> B is granted every cycle and a_grant stays 0 until B deasserts.
- B stores 16'hBEEF to stack address 16'h0003 while A loads memory address 16'h0003 (holding 16'h0000) -> only the stack enable pulses; A's load returns 16'h0000; a later B stack load returns 16'hBEEF.
- Interleaved loads: grant A (addr 1), then B (addr 2), with memory[1]=16'h0001 and memory[2]=16'h0002 -> a_rvalid with 16'h0001, then b_rvalid with 16'h0002 on consecutive cycles, never both high.
- A load is granted, then reset is asserted the next cycle -> no rvalid is seen, enables are 0 during reset, and A is granted first after reset when both request.
